mem_port_arbiter: RTL and testbench

// - Shares the single-port erasable memory between two requesters.
// - Requester 0 is the instruction sequencer, which drives fetches and stores.
// - Requester 1 is the involuntary counter-increment unit, which steals cycles.
// - Serialises accesses with a req/ack handshake and drives the one memory port.
// - Counter unit has fixed priority; a starvation limiter guarantees sequencer progress.

---
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for one memory port (counter unit priority + starvation limit; ARB_RR_EN = round-robin).
// Latency: write ack at T+2, read ack at T+2+MEM_LAT; requesters hold req/payload until their ack pulse.
module mem_port_arbiter #(
  parameter int AW        = 12,
  parameter int DW        = 16,
  parameter int MEM_LAT   = 1,
  parameter int MAX_STEAL = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          seq_req,
  input  logic          seq_we,
  input  logic [AW-1:0] seq_addr,
  input  logic [DW-1:0] seq_wdata,
  output logic          seq_ack,
  output logic [DW-1:0] seq_rdata,
  input  logic          cnt_req,
  input  logic          cnt_we,
  input  logic [AW-1:0] cnt_addr,
  input  logic [DW-1:0] cnt_wdata,
  output logic          cnt_ack,
  output logic [DW-1:0] cnt_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t        state_q, state_d;
  logic          gnt_q, gnt_d;          // 1 = counter unit owns the transaction
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [DW-1:0] seq_rdata_q, seq_rdata_d;
  logic [DW-1:0] cnt_rdata_q, cnt_rdata_d;
  logic          pick_cnt;

`ifdef ARB_RR_EN
  logic last_q, last_d;

  always_comb begin
    pick_cnt = cnt_req && (!seq_req || !last_q);
    last_d   = last_q;
    if (state_q == IDLE && (seq_req || cnt_req)) begin
      last_d = pick_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  localparam int SW = (MAX_STEAL > 0) ? $clog2(MAX_STEAL + 1) : 1;

  logic [SW-1:0] steal_q, steal_d;

  // Counter unit wins contention until it has stolen MAX_STEAL grants in a row.
  always_comb begin
    pick_cnt = cnt_req && (!seq_req || (steal_q != SW'(MAX_STEAL)));
    steal_d  = steal_q;
    if (state_q == IDLE) begin
      if (!seq_req) begin
        steal_d = '0;
      end else if (pick_cnt) begin
        if (steal_q != SW'(MAX_STEAL)) begin
          steal_d = steal_q + SW'(1);
        end
      end else begin
        steal_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      steal_q <= '0;
    end else begin
      steal_q <= steal_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lat_d       = lat_q;
    seq_rdata_d = seq_rdata_q;
    cnt_rdata_d = cnt_rdata_q;
    case (state_q)
      IDLE: begin
        if (seq_req || cnt_req) begin
          gnt_d   = pick_cnt;
          we_d    = pick_cnt ? cnt_we    : seq_we;
          addr_d  = pick_cnt ? cnt_addr  : seq_addr;
          wdata_d = pick_cnt ? cnt_wdata : seq_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        lat_d   = '0;
        state_d = we_q ? DONE : WAIT;
      end
      WAIT: begin
        if (lat_q == LW'(MEM_LAT - 1)) begin
          if (gnt_q) begin
            cnt_rdata_d = mem_rdata;
          end else begin
            seq_rdata_d = mem_rdata;
          end
          state_d = DONE;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lat_q       <= '0;
      seq_rdata_q <= '0;
      cnt_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lat_q       <= lat_d;
      seq_rdata_q <= seq_rdata_d;
      cnt_rdata_q <= cnt_rdata_d;
    end
  end

  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign seq_ack   = (state_q == DONE) && !gnt_q;
  assign cnt_ack   = (state_q == DONE) && gnt_q;
  assign seq_rdata = seq_rdata_q;
  assign cnt_rdata = cnt_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a one-cycle-latency memory model.
module tb_mem_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          seq_req, seq_we, cnt_req, cnt_we;
  logic [AW-1:0] seq_addr, cnt_addr;
  logic [DW-1:0] seq_wdata, cnt_wdata;
  logic          seq_ack, cnt_ack, mem_en, mem_we, busy;
  logic [DW-1:0] seq_rdata, cnt_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_dat;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_dat;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .MAX_STEAL(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .seq_req(seq_req), .seq_we(seq_we), .seq_addr(seq_addr), .seq_wdata(seq_wdata),
    .seq_ack(seq_ack), .seq_rdata(seq_rdata),
    .cnt_req(cnt_req), .cnt_we(cnt_we), .cnt_addr(cnt_addr), .cnt_wdata(cnt_wdata),
    .cnt_ack(cnt_ack), .cnt_rdata(cnt_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_we = 1'b1; pre_addr = a; pre_dat = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    seq_req = 0; seq_we = 0; seq_addr = '0; seq_wdata = '0;
    cnt_req = 0; cnt_we = 0; cnt_addr = '0; cnt_wdata = '0;
    pre_we = 0; pre_addr = '0; pre_dat = '0;
    #2;
    n_chk++;
    if ({mem_en, mem_we, seq_ack, cnt_ack, busy} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {mem_en, mem_we, seq_ack, cnt_ack, busy});
    end
    n_chk++;
    if ({mem_addr, mem_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_mem_bus: got addr %h wdata %h want 0", mem_addr, mem_wdata);
    end
    n_chk++;
    if ({seq_rdata, cnt_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_rdata: got %h %h want 0", seq_rdata, cnt_rdata);
    end
    @(negedge clk);
    preload(12'h012, 16'h1234);
    preload(12'h030, 16'hBEEF);
    preload(12'h041, 16'h0000);
    preload(12'h020, 16'hFFFF);
    rst_n = 1'b1;
  endtask

  task automatic test_seq_read;
    @(negedge clk);
    seq_req = 1; seq_we = 0; seq_addr = 12'h012;
    @(negedge clk);
    n_chk++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 12'h012}) begin
      n_fail++; $display("FAIL rd_issue: got en=%b we=%b addr=%h want 1 0 012", mem_en, mem_we, mem_addr);
    end
    @(negedge clk);
    n_chk++;
    if ({seq_ack, mem_en} !== 2'b00) begin
      n_fail++; $display("FAIL rd_wait: got ack=%b en=%b want 0 0", seq_ack, mem_en);
    end
    @(negedge clk);
    n_chk++;
    if ({seq_ack, cnt_ack, seq_rdata} !== {1'b1, 1'b0, 16'h1234}) begin
      n_fail++; $display("FAIL rd_ack: got ack=%b cack=%b rdata=%h want 1 0 1234", seq_ack, cnt_ack, seq_rdata);
    end
    seq_req = 0;
    @(negedge clk);
    n_chk++;
    if ({seq_ack, busy, seq_rdata} !== {1'b0, 1'b0, 16'h1234}) begin
      n_fail++; $display("FAIL rd_hold: got ack=%b busy=%b rdata=%h want 0 0 1234", seq_ack, busy, seq_rdata);
    end
  endtask

  task automatic test_cnt_write;
    @(negedge clk);
    cnt_req = 1; cnt_we = 1; cnt_addr = 12'h020; cnt_wdata = 16'h0007;
    @(negedge clk);
    n_chk++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 12'h020, 16'h0007}) begin
      n_fail++; $display("FAIL wr_issue: got en=%b we=%b addr=%h wd=%h want 1 1 020 0007", mem_en, mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    n_chk++;
    if ({cnt_ack, seq_ack} !== 2'b10) begin
      n_fail++; $display("FAIL wr_ack: got cack=%b sack=%b want 1 0", cnt_ack, seq_ack);
    end
    cnt_req = 0; cnt_we = 0;
    @(negedge clk);
    n_chk++;
    if (mem[12'h020] !== 16'h0007) begin
      n_fail++; $display("FAIL wr_mem: got %h want 0007", mem[12'h020]);
    end
    n_chk++;
    if ({cnt_rdata, seq_rdata} !== {16'h0000, 16'h1234}) begin
      n_fail++; $display("FAIL wr_rdata_keep: got %h %h want 0000 1234", cnt_rdata, seq_rdata);
    end
  endtask

  task automatic test_contention;
    int exp_order [10];
    int got [10];
    int n = 0;
    int overlaps = 0;
    int adjacent = 0;
    logic prev_en = 1'b0;
`ifdef ARB_RR_EN
    exp_order = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
`endif
    @(negedge clk);
    seq_req = 1; seq_we = 0; seq_addr = 12'h012;
    cnt_req = 1; cnt_we = 0; cnt_addr = 12'h030;
    for (int c = 0; c < 100 && n < 10; c++) begin
      @(negedge clk);
      if (seq_ack && cnt_ack) overlaps++;
      if (mem_en && prev_en) adjacent++;
      prev_en = mem_en;
      if (cnt_ack) begin
        got[n] = 1; n++;
        n_chk++;
        if (cnt_rdata !== 16'hBEEF) begin
          n_fail++; $display("FAIL arb_cnt_rdata: got %h want BEEF", cnt_rdata);
        end
      end else if (seq_ack) begin
        got[n] = 0; n++;
        n_chk++;
        if (seq_rdata !== 16'h1234) begin
          n_fail++; $display("FAIL arb_seq_rdata: got %h want 1234", seq_rdata);
        end
      end
    end
    seq_req = 0; cnt_req = 0;
    n_chk++;
    if (n != 10) begin
      n_fail++; $display("FAIL arb_timeout: got %0d acks want 10", n);
    end
    for (int i = 0; i < n; i++) begin
      n_chk++;
      if (got[i] != exp_order[i]) begin
        n_fail++; $display("FAIL arb_order[%0d]: got %0d want %0d (1=cnt)", i, got[i], exp_order[i]);
      end
    end
    n_chk++;
    if (overlaps != 0 || adjacent != 0) begin
      n_fail++; $display("FAIL arb_spacing: got overlaps=%0d adjacent_en=%0d want 0 0", overlaps, adjacent);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int acks = 0;
    @(negedge clk);
    seq_req = 1; seq_we = 0; seq_addr = 12'h012;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({mem_en, mem_we, seq_ack, cnt_ack, busy, mem_addr, mem_wdata, seq_rdata, cnt_rdata} !== '0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got busy=%b addr=%h srd=%h crd=%h want all 0", busy, mem_addr, seq_rdata, cnt_rdata);
    end
    seq_req = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (seq_ack || cnt_ack) acks++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (seq_ack || cnt_ack) acks++;
    end
    n_chk++;
    if (acks != 0) begin
      n_fail++; $display("FAIL rst_mid_no_ack: got %0d acks want 0", acks);
    end
    seq_req = 1; seq_we = 0; seq_addr = 12'h012;
    @(negedge clk);
    n_chk++;
    if (mem_en !== 1'b1) begin
      n_fail++; $display("FAIL rst_after_issue: got en=%b want 1", mem_en);
    end
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if ({seq_ack, seq_rdata} !== {1'b1, 16'h1234}) begin
      n_fail++; $display("FAIL rst_after_ack: got ack=%b rdata=%h want 1 1234", seq_ack, seq_rdata);
    end
    seq_req = 0;
    @(negedge clk);
  endtask

  task automatic test_req_drop;
    int acks = 0;
    @(negedge clk);
    seq_req = 1; seq_we = 0; seq_addr = 12'h030;
    @(negedge clk);
    seq_req = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (seq_ack) acks++;
    end
    n_chk++;
    if (acks != 1) begin
      n_fail++; $display("FAIL drop_ack_count: got %0d want 1", acks);
    end
    n_chk++;
    if ({seq_rdata, busy} !== {16'hBEEF, 1'b0}) begin
      n_fail++; $display("FAIL drop_rdata: got rdata=%h busy=%b want BEEF 0", seq_rdata, busy);
    end
  endtask

  task automatic test_payload_latch;
    @(negedge clk);
    seq_req = 1; seq_we = 1; seq_addr = 12'h040; seq_wdata = 16'h5555;
    @(negedge clk);
    n_chk++;
    if ({mem_addr, mem_wdata} !== {12'h040, 16'h5555}) begin
      n_fail++; $display("FAIL latch_issue: got addr=%h wd=%h want 040 5555", mem_addr, mem_wdata);
    end
    seq_addr = 12'h041; seq_wdata = 16'hAAAA;
    @(negedge clk);
    n_chk++;
    if (seq_ack !== 1'b1) begin
      n_fail++; $display("FAIL latch_ack: got %b want 1", seq_ack);
    end
    seq_req = 0; seq_we = 0;
    @(negedge clk);
    n_chk++;
    if ({mem[12'h040], mem[12'h041]} !== {16'h5555, 16'h0000}) begin
      n_fail++; $display("FAIL latch_mem: got %h %h want 5555 0000", mem[12'h040], mem[12'h041]);
    end
    n_chk++;
    if (seq_rdata !== 16'hBEEF) begin
      n_fail++; $display("FAIL latch_rdata_keep: got %h want BEEF", seq_rdata);
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] mask = '0;
    @(negedge clk);
    seq_req = 1; seq_we = 1; seq_addr = 12'h050; seq_wdata = 16'h0001;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      mask[i] = seq_ack;
      if (i == 8) begin
        seq_req = 0; seq_we = 0;
      end
    end
    n_chk++;
    if (mask !== 10'h124) begin
      n_fail++; $display("FAIL b2b_ack_cycles: got %b want %b", mask, 10'h124);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle: got busy=%b want 0", busy);
    end
  endtask

  initial begin
    test_reset;
    test_seq_read;
    test_cnt_write;
    test_contention;
    test_reset_mid;
    test_req_drop;
    test_payload_latch;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
